// File: rtl/pe_seq_if.sv
// Handshake and PE-side signal bundle for pe_sequencer.
// Macro PE_SEQ_FILTER_REUSE_EN adds the reuse_filter request bit.
interface pe_seq_if;
    logic       start;
    logic       busy;
    logic       done;
`ifdef PE_SEQ_FILTER_REUSE_EN
    logic       reuse_filter;
`endif
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       load_filter;
    logic       load_ifmap;
    logic [5:0] ld_addr_filter;
    logic [3:0] ld_addr_ifmap;
    logic [7:0] filter;
    logic [7:0] ifmap;
    logic       en;
    logic [5:0] sel_filter_addr;
    logic [3:0] sel_ifmap_addr;
    logic [3:0] psum_sel;
    logic       en_psum_in;
    logic       en_psum_out;
    logic [7:0] psum_pe;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
`ifdef PE_SEQ_FILTER_REUSE_EN
        input  reuse_filter,
`endif
        input  start, in_valid, in_data, psum_pe, out_ready,
        output busy, done, in_ready, load_filter, load_ifmap,
        output ld_addr_filter, ld_addr_ifmap, filter, ifmap,
        output en, sel_filter_addr, sel_ifmap_addr, psum_sel,
        output en_psum_in, en_psum_out, out_valid, out_data
    );

    modport slave (
`ifdef PE_SEQ_FILTER_REUSE_EN
        output reuse_filter,
`endif
        output start, in_valid, in_data, psum_pe, out_ready,
        input  busy, done, in_ready, load_filter, load_ifmap,
        input  ld_addr_filter, ld_addr_ifmap, filter, ifmap,
        input  en, sel_filter_addr, sel_ifmap_addr, psum_sel,
        input  en_psum_in, en_psum_out, out_valid, out_data
    );
endinterface

// File: rtl/pe_sequencer.sv
// Loads filter/ifmap rows into a PE, issues 1-D convolution taps, then reads back psums.
// Macro PE_SEQ_FILTER_REUSE_EN lets a job skip the filter load once one has completed.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_F  | writing FILT_LEN filter words into the PE
// LOAD_I  | writing IFMAP_LEN ifmap words into the PE
// MAC     | issuing NOUT*FILT_LEN taps
// DRAIN   | letting the PE pipeline settle, addresses frozen
// RD_WAIT | psum read address presented, waiting PIPE_LAT cycles
// OUT     | holding a result until the consumer takes it
module pe_sequencer #(
    parameter int FILT_LEN  = 3,
    parameter int IFMAP_LEN = 5,
    parameter int PIPE_LAT  = 3
) (
    input  logic      clk,
    input  logic      rst,
    pe_seq_if.master  bus
);
    if (FILT_LEN < 1 || FILT_LEN > 64) begin : g_bad_filt_len
        $error("pe_sequencer: FILT_LEN must be 1..64");
    end
    if (IFMAP_LEN < FILT_LEN || IFMAP_LEN > 16) begin : g_bad_ifmap_len
        $error("pe_sequencer: IFMAP_LEN must be FILT_LEN..16");
    end
    if (PIPE_LAT < 1 || PIPE_LAT > 256) begin : g_bad_pipe_lat
        $error("pe_sequencer: PIPE_LAT must be 1..256");
    end

    localparam int         NOUT     = IFMAP_LEN - FILT_LEN + 1;
    localparam logic [5:0] F_LAST   = 6'(FILT_LEN - 1);
    localparam logic [3:0] I_LAST   = 4'(IFMAP_LEN - 1);
    localparam logic [3:0] J_LAST   = 4'(NOUT - 1);
    localparam logic [7:0] LAT_INIT = 8'(PIPE_LAT - 1);

    typedef enum logic [2:0] {IDLE, LOAD_F, LOAD_I, MAC, DRAIN, RD_WAIT, OUT} state_t;

    state_t     state, state_nxt;
    logic [5:0] f_idx, k;
    logic [3:0] i_idx, j, m;
    logic [7:0] lat;
    logic [7:0] filter_q, ifmap_q, out_data_q;
    logic       done_q;
    logic       skip_f;

`ifdef PE_SEQ_FILTER_REUSE_EN
    logic filter_loaded;
    assign skip_f = bus.reuse_filter & filter_loaded;
`else
    assign skip_f = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.in_ready    = 1'b0;
        bus.load_filter = 1'b0;
        bus.load_ifmap  = 1'b0;
        bus.en          = 1'b0;
        bus.en_psum_out = 1'b0;
        bus.out_valid   = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = skip_f ? LOAD_I : LOAD_F;
            LOAD_F: begin
                bus.in_ready    = 1'b1;
                bus.load_filter = bus.in_valid;
                if (bus.in_valid && f_idx == F_LAST) state_nxt = LOAD_I;
            end
            LOAD_I: begin
                bus.in_ready   = 1'b1;
                bus.load_ifmap = bus.in_valid;
                if (bus.in_valid && i_idx == I_LAST) state_nxt = MAC;
            end
            MAC: begin
                bus.en = 1'b1;
                if (k == F_LAST && j == J_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                bus.en = 1'b1;
                if (lat == '0) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                bus.en_psum_out = 1'b1;
                if (lat == '0) state_nxt = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = (j == J_LAST) ? IDLE : RD_WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address registers only move inside their own phase, so they hold elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_idx      <= '0;
            i_idx      <= '0;
            k          <= '0;
            j          <= '0;
            m          <= '0;
            lat        <= '0;
            filter_q   <= '0;
            ifmap_q    <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
`ifdef PE_SEQ_FILTER_REUSE_EN
            filter_loaded <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    if (skip_f) i_idx <= '0;
                    else        f_idx <= '0;
                end
                LOAD_F: if (bus.in_valid) begin
                    filter_q <= bus.in_data;
                    if (f_idx == F_LAST) begin
                        i_idx <= '0;
`ifdef PE_SEQ_FILTER_REUSE_EN
                        filter_loaded <= 1'b1;
`endif
                    end else begin
                        f_idx <= f_idx + 6'd1;
                    end
                end
                LOAD_I: if (bus.in_valid) begin
                    ifmap_q <= bus.in_data;
                    if (i_idx == I_LAST) begin
                        k <= '0;
                        j <= '0;
                        m <= '0;
                    end else begin
                        i_idx <= i_idx + 4'd1;
                    end
                end
                MAC: begin
                    if (k == F_LAST) begin
                        if (j == J_LAST) begin
                            lat <= LAT_INIT;
                        end else begin
                            k <= '0;
                            j <= j + 4'd1;
                            m <= j + 4'd1;
                        end
                    end else begin
                        k <= k + 6'd1;
                        m <= m + 4'd1;
                    end
                end
                DRAIN: begin
                    if (lat == '0) begin
                        j   <= '0;
                        lat <= LAT_INIT;
                    end else begin
                        lat <= lat - 8'd1;
                    end
                end
                RD_WAIT: begin
                    if (lat == '0) out_data_q <= bus.psum_pe;
                    else           lat <= lat - 8'd1;
                end
                OUT: if (bus.out_ready) begin
                    if (j == J_LAST) begin
                        done_q <= 1'b1;
                    end else begin
                        j   <= j + 4'd1;
                        lat <= LAT_INIT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy            = (state != IDLE);
    assign bus.done            = done_q;
    assign bus.ld_addr_filter  = f_idx;
    assign bus.ld_addr_ifmap   = i_idx;
    assign bus.filter          = (state == LOAD_F && bus.in_valid) ? bus.in_data : filter_q;
    assign bus.ifmap           = (state == LOAD_I && bus.in_valid) ? bus.in_data : ifmap_q;
    assign bus.sel_filter_addr = k;
    assign bus.sel_ifmap_addr  = m;
    assign bus.psum_sel        = j;
    assign bus.en_psum_in      = 1'b0;
    assign bus.out_data        = out_data_q;
endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL provide parameter FILT_LEN, default 3, filter taps per row (1..64).
REQ-002 SHALL provide parameter IFMAP_LEN, default 5, ifmap words per row (FILT_LEN..16); NOUT = IFMAP_LEN-FILT_LEN+1.
REQ-003 SHALL provide parameter PIPE_LAT, default 3, cycles from issued PE address to settled PE psum.
REQ-004 SHALL have ports, clock and reset first:
 clk  in  1  sole clock, rising edge;
 rst  in  1  asynchronous active-high reset;
 start  in  1  one-cycle job request;
 busy  out  1  high while a job is running;
 done  out  1  one-cycle pulse when the job completes;
 in_valid  in  1  upstream word valid;
 in_ready  out  1  sequencer accepts the word;
 in_data  in  8  FILT_LEN filter words, then IFMAP_LEN ifmap words;
 load_filter, load_ifmap  out  1  PE spad write strobes;
 ld_addr_filter  out  6, ld_addr_ifmap  out  4  PE write addresses;
 filter, ifmap  out  8  PE write data;
 en  out  1  PE MAC enable;
 sel_filter_addr  out  6, sel_ifmap_addr  out  4, psum_sel  out  4  PE read addresses;
 en_psum_in  out  1  tied 0;
 en_psum_out  out  1  PE psum output enable;
 psum_pe  in  8  PE psum_out;
 out_valid  out  1, out_ready  in  1, out_data  out  8  result stream.

Function
REQ-005 SHALL implement states IDLE, LOAD_F, LOAD_I, MAC, DRAIN, RD_WAIT, OUT.
REQ-006 IDLE: start=1 SHALL go to LOAD_F and set busy next cycle; start SHALL be ignored while busy.
REQ-007 in_ready SHALL be 1 only in LOAD_F/LOAD_I; a word transfers when in_valid&in_ready.
REQ-008 Each LOAD_F transfer SHALL drive load_filter=1, filter=in_data, ld_addr_filter=word index 0..FILT_LEN-1 in the same cycle; after word FILT_LEN-1, go to LOAD_I.
REQ-009 LOAD_I SHALL do the same with load_ifmap/ifmap/ld_addr_ifmap for indices 0..IFMAP_LEN-1, then go to MAC.
REQ-010 load strobes SHALL be 0 in cycles without a transfer; in_valid gaps SHALL stall without losing the index.
REQ-011 MAC SHALL issue one tap per cycle, en=1, for j=0..NOUT-1 (outer) and k=0..FILT_LEN-1 (inner): sel_filter_addr=k, sel_ifmap_addr=j+k, psum_sel=j; NOUT*FILT_LEN cycles total.
REQ-012 DRAIN SHALL hold en=1, with the addresses frozen at the last tap, for PIPE_LAT cycles, then go to RD_WAIT with j=0.
REQ-013 RD_WAIT SHALL drive psum_sel=j, en_psum_out=1, en=0 for PIPE_LAT cycles, then capture psum_pe into out_data and go to OUT.
REQ-014 OUT SHALL hold out_valid=1 and out_data stable until out_ready=1; on the handshake, j increments and the state returns to RD_WAIT, or, after j=NOUT-1, goes to IDLE with done=1 for one cycle and busy=0.
REQ-015 out_data SHALL wrap modulo 256 as delivered by the PE; no saturation.
REQ-016 Outside the states named above, every strobe/enable output SHALL be 0 and the address outputs SHALL hold their last value.
REQ-017 Parameter values out of range SHALL be rejected at elaboration.

Reset
REQ-018 rst=1 SHALL immediately force IDLE and clear all counters, all address/data outputs, busy, done, in_ready, out_valid, en, en_psum_out and the load strobes to 0.
REQ-019 Reset mid-job SHALL abandon the job without a done pulse; the next start SHALL begin a fresh LOAD_F.

Configuration
REQ-020 With `PE_SEQ_FILTER_REUSE_EN` defined, the block SHALL add input reuse_filter (1 bit); start with reuse_filter=1 SHALL skip LOAD_F and go directly to LOAD_I, provided a complete filter load has occurred since reset; otherwise it SHALL behave as reuse_filter=0.
REQ-021 Without the macro, the reuse_filter port SHALL be absent and every job SHALL load the filter.

Verification (FILT_LEN=3, IFMAP_LEN=5, PIPE_LAT=3)
REQ-022 Filter {1,2,3}, ifmap {1,1,1,1,1}, ideal PE model -> out_data 6,6,6, then one done pulse.
REQ-023 in_valid toggling 1/0 during load -> ld_addr sequences 0,1,2 and 0..4 with no gaps or repeats; MAC issues exactly 9 taps with (k, j+k) pairs (0,0)(1,1)(2,2)(0,1)...(2,4).
REQ-024 out_ready held 0 for 5 cycles on the first result -> out_valid and out_data stable throughout; the second RD_WAIT starts only after the handshake.
REQ-025 rst asserted during MAC -> all outputs 0 in that cycle, no done pulse; the following job yields correct results.
REQ-026 start pulsed while busy -> ignored; exactly one done pulse per accepted start.
REQ-027 With `PE_SEQ_FILTER_REUSE_EN`: a second job with reuse_filter=1 -> no load_filter strobe, 5 ifmap loads, correct outputs; reuse_filter=1 as the first job after reset -> full filter load.
